bp_be_fma_wb_scheduler: RTL
===========================

Name: bp_be_fma_wb_scheduler

Overview:
- Issue-side scheduler for the shared FMA/IMUL pipe.
- Tracks every in-flight op in per-result-port slot shift registers and drives the writeback valid/rd pair in lock-step with the pipe.
- Arbitrates the FP writeback port between the fixed-latency FMA path and the variable-latency FP divider, with starvation protection for the divider.
- Handles flush kills and answers RAW-hazard queries from the issue stage.

Parameters:
- fma_latency_p, 4, FMA latency: result valid fma_latency_p-1 cycles after the issue cycle (must be >=3).
- imul_latency_p, 3, IMUL latency: result valid imul_latency_p-1 cycles after the issue cycle (must be >=2).
- kill_depth_p, 1, number of youngest slot stages cleared by flush_i (must be <= imul_latency_p-1).
- starve_limit_p, 4, consecutive denied divider cycles before FMA issue is blocked.
- rd_width_p, 5, destination register address width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- issue_v_i  in  1  issue request this cycle.
- issue_is_fma_i  in  1  1=FMA op (FP result), 0=IMUL op (int result).
- issue_rd_i  in  rd_width_p  destination register.
- ready_o  out  1  issue accepted when issue_v_i&ready_o.
- flush_i  in  1  kill young in-flight ops and the current issue.
- div_req_i  in  1  FP divider holds a result for the FP writeback port.
- div_gnt_o  out  1  divider may write back in the next cycle.
- fma_wb_v_o  out  1  FMA result on the FP writeback port this cycle.
- fma_wb_rd_o  out  rd_width_p  its destination.
- imul_wb_v_o  out  1  IMUL result on the int writeback port this cycle.
- imul_wb_rd_o  out  rd_width_p  its destination.
- query_rd_i  in  rd_width_p  issue-stage source register to check.
- query_fp_hit_o  out  1  a valid FP slot targets query_rd_i.
- query_int_hit_o  out  1  a valid int slot targets query_rd_i.
- busy_o  out  1  any slot valid.

Behaviour:
- Slot structures:
  - FP shift register: stages 1..fma_latency_p-1, each {v, rd}.
  - Int shift register: stages 1..imul_latency_p-1, each {v, rd}.
  - Both shift by one stage every cycle; the last stage drives the wb outputs (registered, no combinational path from the issue inputs).
- Accept: accept = issue_v_i & ready_o & ~flush_i.
  - Stage 1 of the selected register loads {1, issue_rd_i}.
  - Stage 1 of the other register loads v=0.
  - Result: an FMA issued in cycle t gives fma_wb_v_o=1 in cycle t+fma_latency_p-1. An IMUL issued in cycle t gives imul_wb_v_o=1 in cycle t+imul_latency_p-1.
- ready_o:
  - Forced to 0 while reset_n_i is low.
  - Otherwise ready_o = ~(issue_is_fma_i & starve_block).
  - IMUL is never blocked.
- Divider grant:
  - div_gnt_o = div_req_i & ~fp_stage[fma_latency_p-2].v & reset_n_i.
  - This guarantees the cycle after a grant has no FMA writeback.
  - An FMA accepted in the grant cycle lands at t+fma_latency_p-1 >= t+2, so no collision.
- Starvation counter (width clog2(starve_limit_p+1)):
  - If div_req_i & ~div_gnt_o: increment, saturating at starve_limit_p.
  - Otherwise: clear to 0.
  - starve_block = (count == starve_limit_p).
  - While blocked, no new FMA enters, so a grant occurs within fma_latency_p-2 cycles.
- Flush:
  - In the flush cycle, stages 1..kill_depth_p of both registers load v=0 at the next edge (their shifted-in contents are dropped).
  - The current issue is not accepted.
  - Older stages shift normally and still write back.
  - flush_i does not affect div_gnt_o or the starvation counter.
- Queries: combinational OR across all valid stages of the respective register; the last stage is included. Data outputs are don't-care when the matching valid is 0.
- busy_o: OR of all v bits, registered-stage based.
- Reset (async assert, sync release):
  - All v=0, counter=0.
  - Outputs: fma_wb_v_o=0, imul_wb_v_o=0, busy_o=0, query hits=0, div_gnt_o=0, ready_o=0.
  - rd fields are don't-care.
  - Reset mid-operation discards all in-flight ops; no writeback occurs for them.
- Simultaneous events:
  - IMUL and FMA writebacks may coincide (different ports).
  - Issue + div grant in the same cycle is legal.
  - Flush + issue: flush wins.

Decomposition:
- Shared package bp_be_pkg gets:
  - typedef bp_be_wb_slot_s {v, rd}.
  - Constant for the default kill depth.
- Sub-module bp_be_wb_slot_shifter (params: depth_p, kill_depth_p, rd_width_p; ports: load, kill, query):
  - Instantiated twice (FP, int).
  - Each contains its own async-reset flops.

Test Plan:
- FMA issue rd=7 at cycle 10, no flush -> fma_wb_v_o=1, fma_wb_rd_o=7 only in cycle 13; query_rd_i=7 gives query_fp_hit_o=1 in cycles 11-13, 0 in cycle 14.
- IMUL rd=3 at cycle 5 and FMA rd=4 at cycle 4 -> both writebacks in cycle 7 (imul_wb_rd_o=3, fma_wb_rd_o=4).
- div_req_i held high while FMAs issue every cycle from cycle 0 -> div_gnt_o=0 during cycles 2-5, counter reaches 4 at cycle 6, ready_o=0 for FMA in cycle 6, div_gnt_o=1 by cycle 8, counter clears after the grant.
- FMA rd=1 at cycle 0, FMA rd=2 at cycle 1, flush_i at cycle 1 -> rd=1 writes back in cycle 3; rd=2 never appears; busy_o=0 from cycle 4.
- reset_n_i deasserted asynchronously mid-cycle with 3 ops in flight -> all wb valids and busy_o drop immediately with no clock edge; no writebacks after release.
- IMUL issued while starve_block=1 -> accepted (ready_o=1), imul_wb_v_o two cycles later.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared backend types and constants for the FMA/IMUL writeback scheduler.
package bp_be_pkg;

    localparam int bp_be_rd_width_gp   = 5;
    localparam int bp_be_kill_depth_gp = 1;

    typedef struct packed {
        logic                         v;
        logic [bp_be_rd_width_gp-1:0] rd;
    } bp_be_wb_slot_s;

endpackage

// File: rtl/bp_be_wb_slot_shifter.sv
// One result port's in-flight slot shift register: stage 1 loads, the last stage drives writeback.
module bp_be_wb_slot_shifter #(
    parameter int depth_p      = 3,
    parameter int kill_depth_p = 1,
    parameter int rd_width_p   = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  load_v_i,
    input  logic [rd_width_p-1:0] load_rd_i,
    input  logic                  kill_i,
    input  logic [rd_width_p-1:0] query_rd_i,
    output logic                  query_hit_o,
    output logic [depth_p-1:0]    stage_v_o,
    output logic                  last_v_o,
    output logic [rd_width_p-1:0] last_rd_o
);

    logic [depth_p-1:0]    v_q, v_d;
    logic [rd_width_p-1:0] rd_q [depth_p];
    logic [rd_width_p-1:0] rd_d [depth_p];

    // Index i holds stage i+1; a kill drops whatever would land in stages 1..kill_depth_p.
    always_comb begin
        v_d     = '0;
        v_d[0]  = load_v_i & ~kill_i;
        rd_d[0] = load_rd_i;
        for (int i = 1; i < depth_p; i++) begin
            v_d[i]  = v_q[i-1] & ~(kill_i && (i < kill_depth_p));
            rd_d[i] = rd_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q <= '0;
            for (int i = 0; i < depth_p; i++) rd_q[i] <= '0;
        end else begin
            v_q <= v_d;
            for (int i = 0; i < depth_p; i++) rd_q[i] <= rd_d[i];
        end
    end

    always_comb begin
        query_hit_o = 1'b0;
        for (int i = 0; i < depth_p; i++) begin
            if (v_q[i] && (rd_q[i] == query_rd_i)) query_hit_o = 1'b1;
        end
    end

    assign stage_v_o = v_q;
    assign last_v_o  = v_q[depth_p-1];
    assign last_rd_o = rd_q[depth_p-1];

endmodule

// File: rtl/bp_be_fma_wb_scheduler.sv
// Issue-side scheduler for the shared FMA/IMUL pipe: tracks in-flight ops, drives writeback,
// and arbitrates the FP writeback port against the divider with starvation protection.
module bp_be_fma_wb_scheduler
    import bp_be_pkg::*;
#(
    parameter int fma_latency_p  = 4,
    parameter int imul_latency_p = 3,
    parameter int kill_depth_p   = bp_be_kill_depth_gp,
    parameter int starve_limit_p = 4,
    parameter int rd_width_p     = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  issue_v_i,
    input  logic                  issue_is_fma_i,
    input  logic [rd_width_p-1:0] issue_rd_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    input  logic                  div_req_i,
    output logic                  div_gnt_o,
    output logic                  fma_wb_v_o,
    output logic [rd_width_p-1:0] fma_wb_rd_o,
    output logic                  imul_wb_v_o,
    output logic [rd_width_p-1:0] imul_wb_rd_o,
    input  logic [rd_width_p-1:0] query_rd_i,
    output logic                  query_fp_hit_o,
    output logic                  query_int_hit_o,
    output logic                  busy_o
);

    localparam int fp_depth_lp  = fma_latency_p - 1;
    localparam int int_depth_lp = imul_latency_p - 1;
    localparam int cnt_w_lp     = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w_lp-1:0] starve_max_lp = cnt_w_lp'(starve_limit_p);

    logic                    accept;
    logic                    starve_block;
    logic [cnt_w_lp-1:0]     starve_cnt_q, starve_cnt_d;
    logic [fp_depth_lp-1:0]  fp_stage_v;
    logic [int_depth_lp-1:0] int_stage_v;

    assign starve_block = (starve_cnt_q == starve_max_lp);
    assign ready_o      = reset_n_i & ~(issue_is_fma_i & starve_block);
    assign accept       = issue_v_i & ready_o & ~flush_i;

    // Stage fma_latency_p-2 becomes the FP writeback stage next cycle; grant only when it is empty.
    assign div_gnt_o = div_req_i & ~fp_stage_v[fma_latency_p-3] & reset_n_i;

    always_comb begin
        starve_cnt_d = '0;
        if (div_req_i & ~div_gnt_o) begin
            starve_cnt_d = starve_block ? starve_cnt_q : starve_cnt_q + cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) starve_cnt_q <= '0;
        else            starve_cnt_q <= starve_cnt_d;
    end

    bp_be_wb_slot_shifter #(
        .depth_p      (fp_depth_lp),
        .kill_depth_p (kill_depth_p),
        .rd_width_p   (rd_width_p)
    ) fp_slots (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_v_i    (accept & issue_is_fma_i),
        .load_rd_i   (issue_rd_i),
        .kill_i      (flush_i),
        .query_rd_i  (query_rd_i),
        .query_hit_o (query_fp_hit_o),
        .stage_v_o   (fp_stage_v),
        .last_v_o    (fma_wb_v_o),
        .last_rd_o   (fma_wb_rd_o)
    );

    bp_be_wb_slot_shifter #(
        .depth_p      (int_depth_lp),
        .kill_depth_p (kill_depth_p),
        .rd_width_p   (rd_width_p)
    ) int_slots (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_v_i    (accept & ~issue_is_fma_i),
        .load_rd_i   (issue_rd_i),
        .kill_i      (flush_i),
        .query_rd_i  (query_rd_i),
        .query_hit_o (query_int_hit_o),
        .stage_v_o   (int_stage_v),
        .last_v_o    (imul_wb_v_o),
        .last_rd_o   (imul_wb_rd_o)
    );

    assign busy_o = (|fp_stage_v) | (|int_stage_v);

endmodule
